// File: rtl/reg_file_sb_if.sv
// Writeback, read, reservation and scoreboard signals of the scoreboarded register file.
interface reg_file_sb_if #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int NR = 2
);
  logic              write_en;
  logic [D-1:0]      waddr;
  logic [W-1:0]      data_in;
  logic [NR*D-1:0]   raddr;
  logic [NR*W-1:0]   data_out;
  logic [NR-1:0]     rd_busy;
  logic              rsv_en;
  logic [D-1:0]      rsv_addr;
  logic              rsv_ack;
  logic              flush;
  logic [2**D-1:0]   busy_vec;

  modport master (
    output write_en, waddr, data_in, raddr, rsv_en, rsv_addr, flush,
    input  data_out, rd_busy, rsv_ack, busy_vec
  );

  modport slave (
    input  write_en, waddr, data_in, raddr, rsv_en, rsv_addr, flush,
    output data_out, rd_busy, rsv_ack, busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with NR combinational read ports, one writeback port and a busy-bit scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data/busy state to the read ports.
module reg_file_sb #(
  parameter int W  = 8,
  parameter int D  = 4,
  parameter int NR = 2
) (
  input logic          CLK,
  input logic          RST_N,
  reg_file_sb_if.slave bus
);
  localparam int N = 2**D;

  logic [W-1:0]    mem_q [N];
  logic [N-1:0]    busy_q;
  logic [N-1:0]    busy_d;
  logic            wr_hit;
  logic            rsv_ack;
  logic [NR*W-1:0] dout;
  logic [NR-1:0]   rdb;
  logic [D-1:0]    ra;

  // Gating with RST_N keeps reset-time inputs from reaching outputs through the bypass.
  assign wr_hit = RST_N && bus.write_en && (bus.waddr != '0);

  always_comb begin
    rsv_ack = RST_N && bus.rsv_en && !bus.flush && (bus.rsv_addr != '0) &&
              (!busy_q[bus.rsv_addr] || (wr_hit && (bus.waddr == bus.rsv_addr)));
  end

  // A reservation wins over a same-address writeback clear; flush wins over both.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (wr_hit)  busy_d[bus.waddr]    = 1'b0;
      if (rsv_ack) busy_d[bus.rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q <= '0;
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_hit) mem_q[bus.waddr] <= bus.data_in;
    end
  end

  always_comb begin
    dout = '0;
    rdb  = '0;
    ra   = '0;
    for (int i = 0; i < NR; i++) begin
      ra = bus.raddr[i*D +: D];
      if (ra != '0) begin
        dout[i*W +: W] = mem_q[ra];
        rdb[i]         = busy_q[ra];
      end
`ifdef REG_FILE_BYPASS_EN
      if (wr_hit && (ra == bus.waddr)) begin
        dout[i*W +: W] = bus.data_in;
        rdb[i]         = rsv_ack && (bus.rsv_addr == bus.waddr);
      end
`endif
    end
  end

  assign bus.data_out = dout;
  assign bus.rd_busy  = rdb;
  assign bus.rsv_ack  = rsv_ack;
  assign bus.busy_vec = busy_q;
endmodule
